uart_tx_fifo: RTL

- Serial UART transmitter: 8 data bits, LSB first, one start bit, STOP_BITS stop bits, no parity.
- Buffers bytes in a small FIFO so the host can queue several bytes and frames go out back-to-back.
- Sits between the host or CPU output port and the board TX pin.
- It is the transmit companion of the existing UART receiver and must run at the same CLKS_PER_BIT.

---
 rtl/uart_tx_fifo.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// ------------
// UART transmitter with a small byte FIFO in front of it. The host queues
// bytes with i_TX_DV / i_TX_Byte. Queued bytes go out as 8N1-style frames:
// one start bit, 8 data bits LSB first, STOP_BITS stop bits, and no parity.
// Frames follow each other with a fixed two-cycle idle gap.
//
// Parameters
//    CLKS_PER_BIT  clocks per bit period (2..65535). Must match the receiver.
//    FIFO_DEPTH    byte entries in the FIFO (power of 2, >= 2)
//    STOP_BITS     number of stop-bit periods (1 or 2)
//
// Ports
//    i_Clock       system clock, rising edge
//    i_Reset       synchronous active-high reset
//    i_TX_DV       write strobe, accepted when o_TX_Ready is high
//    i_TX_Byte     byte to queue
//    o_TX_Ready    FIFO not full
//    o_TX_Serial   registered serial line, idles high
//    o_TX_Active   high while a frame (start, data, stop) is on the line
//    o_TX_Done     one-cycle pulse when the last stop bit completes
//    o_FIFO_Count  bytes waiting in the FIFO (excludes the byte being sent)

module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 217,
   parameter int FIFO_DEPTH   = 4,
   parameter int STOP_BITS    = 1
) (
   input  logic                          i_Clock,
   input  logic                          i_Reset,
   input  logic                          i_TX_DV,
   input  logic [7:0]                    i_TX_Byte,
   output logic                          o_TX_Ready,
   output logic                          o_TX_Serial,
   output logic                          o_TX_Active,
   output logic                          o_TX_Done,
   output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_Count
);

   localparam int PTR_W     = $clog2(FIFO_DEPTH);
   localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;
   localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BIT;

   // The bit timer is 16 bits wide. It only grows to 17 bits for the one
   // corner where two stop bits at a very slow baud exceed 65536 clocks.
   localparam int TIMER_W = (STOP_CLKS > 65536) ? 17 : 16;

   localparam logic [TIMER_W-1:0] BIT_LAST  = TIMER_W'(CLKS_PER_BIT - 1);
   localparam logic [TIMER_W-1:0] STOP_LAST = TIMER_W'(STOP_CLKS - 1);
   localparam logic [CNT_W-1:0]   FULL_COUNT = CNT_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      DATA    = 3'd2,
      STOP    = 3'd3,
      CLEANUP = 3'd4
   } txState_t;

   txState_t             state;
   txState_t             nextState;

   logic [7:0]           fifoMem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wrPtr;
   logic [PTR_W-1:0]     rdPtr;
   logic [CNT_W-1:0]     fifoCount;
   logic                 writeFifo;
   logic                 popFifo;

   logic [7:0]           shiftReg;
   logic [TIMER_W-1:0]   timer;
   logic [TIMER_W-1:0]   nextTimer;
   logic [2:0]           bitIndex;
   logic [2:0]           nextBitIndex;
   logic                 nextSerial;
   logic                 nextActive;
   logic                 nextDone;

   // Ready depends only on the current count. Because of this, a full FIFO
   // refuses a write even on an edge where the transmitter pops a byte.
   assign o_TX_Ready   = (fifoCount != FULL_COUNT);
   assign writeFifo    = i_TX_DV & o_TX_Ready;
   assign o_FIFO_Count = fifoCount;

   // FIFO storage. This block has no reset so the array can map onto plain
   // registers or distributed RAM. The pointers and the count decide
   // whether an entry holds valid data.
   always_ff @(posedge i_Clock) begin
      if (writeFifo) begin
         fifoMem[wrPtr] <= i_TX_Byte;
      end
   end

   // FIFO pointers and occupancy. The depth is a power of two, so the
   // pointers wrap when they overflow. A write and a pop on the same edge
   // cancel out in the count.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         wrPtr     <= '0;
         rdPtr     <= '0;
         fifoCount <= '0;
      end else begin
         if (writeFifo) begin
            wrPtr <= wrPtr + PTR_W'(1);
         end
         if (popFifo) begin
            rdPtr <= rdPtr + PTR_W'(1);
         end
         case ({writeFifo, popFifo})
            2'b10:   fifoCount <= fifoCount + CNT_W'(1);
            2'b01:   fifoCount <= fifoCount - CNT_W'(1);
            default: fifoCount <= fifoCount;
         endcase
      end
   end

   // State register. Reset abandons any frame in progress.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic. The serial, active and done values computed here
   // belong to the state being entered, and they are registered on the
   // same edge. As a result, o_TX_Serial changes exactly when the state
   // changes. The pop decision is made from the count at the start of the
   // cycle, so a byte written into an empty FIFO is not sent before the
   // following edge.
   always_comb begin
      nextState    = state;
      nextTimer    = timer;
      nextBitIndex = bitIndex;
      nextSerial   = 1'b1;
      nextActive   = 1'b0;
      nextDone     = 1'b0;
      popFifo      = 1'b0;

      case (state)
         IDLE: begin
            if (fifoCount != '0) begin
               popFifo      = 1'b1;
               nextState    = START;
               nextTimer    = '0;
               nextBitIndex = '0;
               nextSerial   = 1'b0;
               nextActive   = 1'b1;
            end
         end

         START: begin
            nextSerial = 1'b0;
            nextActive = 1'b1;
            if (timer == BIT_LAST) begin
               nextTimer    = '0;
               nextBitIndex = '0;
               nextState    = DATA;
               nextSerial   = shiftReg[0];
            end else begin
               nextTimer = timer + TIMER_W'(1);
            end
         end

         DATA: begin
            nextActive = 1'b1;
            nextSerial = shiftReg[bitIndex];
            if (timer == BIT_LAST) begin
               nextTimer = '0;
               if (bitIndex == 3'd7) begin
                  nextState  = STOP;
                  nextSerial = 1'b1;
               end else begin
                  nextBitIndex = bitIndex + 3'd1;
                  nextSerial   = shiftReg[bitIndex + 3'd1];
               end
            end else begin
               nextTimer = timer + TIMER_W'(1);
            end
         end

         STOP: begin
            nextActive = 1'b1;
            if (timer == STOP_LAST) begin
               nextTimer  = '0;
               nextState  = CLEANUP;
               nextDone   = 1'b1;
               nextActive = 1'b0;
            end else begin
               nextTimer = timer + TIMER_W'(1);
            end
         end

         CLEANUP: begin
            nextState = IDLE;
         end

         default: begin
            nextState    = IDLE;
            nextTimer    = '0;
            nextBitIndex = '0;
         end
      endcase
   end

   // Datapath registers. The shift register holds its byte for the whole
   // frame. Later activity on i_TX_Byte cannot disturb a frame in flight.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         timer       <= '0;
         bitIndex    <= '0;
         shiftReg    <= '0;
         o_TX_Serial <= 1'b1;
         o_TX_Active <= 1'b0;
         o_TX_Done   <= 1'b0;
      end else begin
         if (popFifo) begin
            shiftReg <= fifoMem[rdPtr];
         end
         timer       <= nextTimer;
         bitIndex    <= nextBitIndex;
         o_TX_Serial <= nextSerial;
         o_TX_Active <= nextActive;
         o_TX_Done   <= nextDone;
      end
   end

endmodule
